cim_seq_ctrl: RTL and testbench
===============================

# cim_seq_ctrl

Digital initiator for the CIM macro interface: runs one full inference step per `start`, from WL spike load through DAC handshake, CIM compute and a 20-channel ADC scan. Captures raw ADC codes for the positive and negative columns and emits signed differential results per output neuron. Sits between the SNN core (frame/bit-plane source, membrane accumulator) and `cim_macro_blackbox`, driving its `dac_*`, `cim_*`, `adc_*` and `bl_sel` ports.

## Interface
- `P_NUM_INPUTS`, 64, WL spike vector width
- `P_ADC_CHANNELS`, 20, BL channels scanned (0..9 positive, 10..19 negative)
- `P_NUM_OUTPUTS`, 10, differential outputs (= `P_ADC_CHANNELS`/2)
- `P_ADC_BITS`, 8, ADC code width
- `P_TIMEOUT`, 255, max cycles waited for any `*_done`/`dac_ready`

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one step; accepted only when `busy`=0
- `wl_in`  in  `P_NUM_INPUTS`  spike bit-plane, sampled on accepted `start`
- `busy`  out  1  high from cycle after accepted `start` to `done`
- `done`  out  1  one-cycle pulse at step end (success or timeout)
- `err_timeout`  out  1  sticky; set on timeout, cleared on next accepted `start`
- `diff_valid`  out  1  one-cycle pulse, coincident with successful `done`
- `diff_data`  out  `P_NUM_OUTPUTS`×(`P_ADC_BITS`+1)  signed pos−neg per neuron, held until next `diff_valid`
- `wl_spike`  out  `P_NUM_INPUTS`  to macro, registered copy of `wl_in`
- `dac_valid`  out  1  to macro
- `dac_ready`  in  1  from macro
- `cim_start`  out  1  to macro, one-cycle pulse
- `cim_done`  in  1  from macro
- `adc_start`  out  1  to macro, one-cycle pulse per channel
- `adc_done`  in  1  from macro
- `bl_sel`  out  $clog2(`P_ADC_CHANNELS`)  channel select
- `bl_data`  in  `P_ADC_BITS`  ADC code for `bl_sel`

## Operation
- States: IDLE → DAC → CIM_GO → CIM_WAIT → ADC_GO → ADC_WAIT → (ADC_GO next channel | DIFF) → FIN → IDLE.
- IDLE: `start`=1 latches `wl_in` into `wl_spike`, clears `err_timeout`, channel index=0.
- DAC: `dac_valid`=1 held until `dac_ready`=1 sampled; then CIM_GO. `wl_spike` stable throughout.
- CIM_GO: `cim_start`=1 for exactly one cycle. CIM_WAIT: wait `cim_done`.
- ADC_GO: `bl_sel`=index, `adc_start`=1 one cycle. ADC_WAIT: on cycle `adc_done`=1, store `bl_data` into raw[index]; index<19 → increment, ADC_GO; index=19 → DIFF.
- `bl_sel` held constant from ADC_GO through the capture cycle; never exceeds `P_ADC_CHANNELS`−1.
- DIFF: `diff_data[i]` = zero-extended raw[i] − zero-extended raw[i+`P_NUM_OUTPUTS`], 9-bit two's complement (range −255..+255, no saturation needed).
- FIN: `done`=1, `diff_valid`=1, → IDLE.
- `cim_done`/`adc_done` outside their WAIT state are ignored; `start` while busy ignored.
- Timeout: counter reset on each state entry; in DAC, CIM_WAIT, ADC_WAIT, reaching `P_TIMEOUT` cycles without the awaited input → `err_timeout`=1, `done`=1, `diff_valid`=0, deassert all macro strobes, → IDLE. `diff_data` keeps prior value.

## Timing
- Reset values: `busy`, `done`, `err_timeout`, `diff_valid`, `dac_valid`, `cim_start`, `adc_start` =0; `wl_spike`, `bl_sel`, `diff_data`, raw array =0; state IDLE.
- Reset mid-operation: next cycle all outputs at reset values; in-flight macro done pulses afterwards ignored.
- `start` at cycle T: DAC at T+1 (`dac_valid`=1); with `dac_ready`=1, `cim_start` at T+2.
- `cim_done` at cycle C: `adc_start` (ch0) at C+1.
- `adc_done` at cycle A (ch k<19): `adc_start` for ch k+1 at A+1.
- `adc_done` for ch19 at A: DIFF at A+1, `done`/`diff_valid` at A+2, `busy`=0 at A+3, new `start` accepted at A+3.
- All outputs registered; no combinational path from macro inputs to macro outputs.

## Test plan
- Behavioural macro, `wl_in` popcount 10 → 20 `adc_start` pulses with `bl_sel` 0..19 in order; `diff_valid` with all `diff_data`=+15.
- Popcount 0 → all `diff_data`=0; popcount 64 → all `diff_data`=+96; `err_timeout`=0.
- Stub macro returning raw pos=0, neg=255 on every channel → `diff_data`=−255 (9'h101) on all neurons.
- `cim_done` held low → `done` exactly `P_TIMEOUT`(255) cycles into CIM_WAIT, `err_timeout`=1, `diff_valid`=0, no `adc_start`; next `start` clears `err_timeout` and completes normally.
- `rst` asserted during ADC_WAIT of ch7 → next cycle all outputs zero, state IDLE; late `adc_done` produces no capture; new `start` runs full scan from ch0.
- `start` pulsed while `busy` and stray `cim_done`/`adc_done` in IDLE → ignored; `dac_ready` low for 5 cycles → `dac_valid` held 6 cycles, `cim_start` one cycle after handshake.

Source files
------------

// File: rtl/cim_seq_ctrl.sv
// cim_seq_ctrl: sequences one CIM inference step (DAC handshake, compute, 20-channel ADC scan) and emits signed pos-neg differences
module cim_seq_ctrl #(
  parameter int P_NUM_INPUTS   = 64,
  parameter int P_ADC_CHANNELS = 20,
  parameter int P_NUM_OUTPUTS  = 10,
  parameter int P_ADC_BITS     = 8,
  parameter int P_TIMEOUT      = 255
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [P_NUM_INPUTS-1:0]                   wl_in,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err_timeout,
  output logic                                      diff_valid,
  output logic [P_NUM_OUTPUTS*(P_ADC_BITS+1)-1:0]   diff_data,
  output logic [P_NUM_INPUTS-1:0]                   wl_spike,
  output logic                                      dac_valid,
  input  logic                                      dac_ready,
  output logic                                      cim_start,
  input  logic                                      cim_done,
  output logic                                      adc_start,
  input  logic                                      adc_done,
  output logic [$clog2(P_ADC_CHANNELS)-1:0]         bl_sel,
  input  logic [P_ADC_BITS-1:0]                     bl_data
);
  localparam int CW = $clog2(P_ADC_CHANNELS);
  localparam int TW = $clog2(P_TIMEOUT + 1);
  localparam int DW = P_ADC_BITS + 1;
  localparam logic [CW-1:0] LAST = CW'(P_ADC_CHANNELS - 1);
  localparam logic [TW-1:0] TLIM = TW'(P_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, DAC, CIM_GO, CIM_WAIT, ADC_GO, ADC_WAIT, DIFF, FIN} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr;
  logic [P_ADC_BITS-1:0] raw [P_ADC_CHANNELS];
  logic go, hit, tmo, cap;
  assign go  = state == IDLE && start;
  assign hit = tmr == TLIM;
  always_comb begin
    state_n = state;
    tmo = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE:     state_n = start ? DAC : IDLE;
      DAC: begin
        state_n = dac_ready ? CIM_GO : DAC;
        tmo = !dac_ready && hit;
      end
      CIM_GO:   state_n = CIM_WAIT;
      CIM_WAIT: begin
        state_n = cim_done ? ADC_GO : CIM_WAIT;
        tmo = !cim_done && hit;
      end
      ADC_GO:   state_n = ADC_WAIT;
      ADC_WAIT: begin
        cap = adc_done;
        state_n = adc_done ? (bl_sel == LAST ? DIFF : ADC_GO) : ADC_WAIT;
        tmo = !adc_done && hit;
      end
      DIFF:     state_n = FIN;
      default:  state_n = IDLE;
    endcase
    if (tmo) state_n = FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmr         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      diff_valid  <= 1'b0;
      err_timeout <= 1'b0;
      dac_valid   <= 1'b0;
      cim_start   <= 1'b0;
      adc_start   <= 1'b0;
      wl_spike    <= '0;
      bl_sel      <= '0;
      diff_data   <= '0;
      for (int i = 0; i < P_ADC_CHANNELS; i++) raw[i] <= '0;
    end else begin
      state       <= state_n;
      tmr         <= state_n != state ? '0 : tmr + 1'b1;
      busy        <= state_n != IDLE;
      done        <= state_n == FIN;
      diff_valid  <= state_n == FIN && !tmo;
      err_timeout <= !go && (err_timeout || tmo);
      dac_valid   <= state_n == DAC;
      cim_start   <= state_n == CIM_GO;
      adc_start   <= state_n == ADC_GO;
      if (go) wl_spike <= wl_in;
      bl_sel      <= go ? '0 : (cap && bl_sel != LAST) ? bl_sel + 1'b1 : bl_sel;
      if (cap) raw[bl_sel] <= bl_data;
      if (state == DIFF)
        for (int i = 0; i < P_NUM_OUTPUTS; i++)
          diff_data[i*DW +: DW] <= {1'b0, raw[i]} - {1'b0, raw[i+P_NUM_OUTPUTS]};
    end
  end
endmodule

// File: tb/tb_cim_seq_ctrl.sv
// tb_cim_seq_ctrl: randomized scoreboard bench for cim_seq_ctrl with a behavioural CIM macro
module tb_cim_seq_ctrl;
  localparam int NC = 20, NO = 10, HANG = 1000000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] wl_in = '0;
  logic busy, done, err_timeout, diff_valid;
  logic [89:0] diff_data;
  logic [63:0] wl_spike;
  logic dac_valid, dac_ready, cim_start, cim_done, adc_start, adc_done;
  logic [4:0] bl_sel;
  logic [7:0] bl_data;
  always #5 clk = ~clk;
  cim_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .wl_in(wl_in), .busy(busy), .done(done),
    .err_timeout(err_timeout), .diff_valid(diff_valid), .diff_data(diff_data), .wl_spike(wl_spike),
    .dac_valid(dac_valid), .dac_ready(dac_ready), .cim_start(cim_start), .cim_done(cim_done),
    .adc_start(adc_start), .adc_done(adc_done), .bl_sel(bl_sel), .bl_data(bl_data)
  );
  typedef struct {
    logic [89:0] diff;
    bit tmo;
    bit cim_to;
    int n_adc;
    int dac_n;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;
  int dac_lat = 0, cim_lat = 1, adc_lat = 1, hang_ch = -1;
  bit stray = 1'b0;
  logic [7:0] code [NC];
  logic [89:0] last_diff = '0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  int dc = 0, cc = 0, ac = 0;
  bit cp = 1'b0, ap = 1'b0;
  logic [4:0] ach = '0;
  initial begin
    dac_ready = 1'b0; cim_done = 1'b0; adc_done = 1'b0; bl_data = '0;
    forever begin
      @(negedge clk);
      cim_done = 1'b0; adc_done = 1'b0; bl_data = 8'($urandom);
      if (stray) begin cim_done = 1'b1; adc_done = 1'b1; end
      dac_ready = dac_valid && dc >= dac_lat;
      dc = dac_valid ? dc + 1 : 0;
      if (cim_start) begin cp = 1'b1; cc = 0; end
      else if (cp) begin
        cc++;
        if (cc >= cim_lat) begin cim_done = 1'b1; cp = 1'b0; end
      end
      if (adc_start) begin ap = 1'b1; ac = 0; ach = bl_sel; end
      else if (ap && int'(ach) != hang_ch) begin
        ac++;
        if (ac >= adc_lat) begin adc_done = 1'b1; bl_data = code[ach]; ap = 1'b0; end
      end
    end
  end
  int cyc = 0, cim_cyc = 0, a19 = 0, adc_idx = 0, adc_n = 0, dac_n = 0;
  logic busy_q = 1'b0, dac_valid_q = 1'b0, done_q = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (busy && !busy_q) begin adc_idx = 0; adc_n = 0; dac_n = 0; end
    if (dac_valid) dac_n++;
    if (cim_start) begin
      chk("cim_after_handshake", {dac_valid_q, dac_ready}, 2'b11);
      cim_cyc = cyc;
    end
    if (adc_start) begin
      chk("bl_sel_order", bl_sel, adc_idx);
      chk("adc_trigger", adc_idx == 0 ? cim_done : adc_done, 1);
      adc_idx++; adc_n++;
    end
    if (bl_sel > 5'd19) chk("bl_sel_range", bl_sel, 19);
    if (adc_done && busy && bl_sel == 5'd19 && adc_n == NC) a19 = cyc;
    if (done_q) chk("busy_after_done", busy, 0);
    if (diff_valid && !done) chk("diff_valid_with_done", done, 1);
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("err_timeout", err_timeout, e.tmo);
        chk("diff_valid", diff_valid, !e.tmo);
        chk("diff_data", diff_data, e.diff);
        chk("adc_pulses", adc_n, e.n_adc);
        chk("dac_valid_cycles", dac_n, e.dac_n);
        if (e.cim_to) chk("cim_timeout_latency", cyc - cim_cyc, 256);
        if (!e.tmo) chk("done_latency", cyc - a19, 1);
      end
    end
    busy_q = busy; dac_valid_q = dac_valid; done_q = done;
  end
  task automatic run_step(input int mode, input logic [63:0] wl, input int dl, input int cl,
                          input int al, input int hc, input bit abort7, input bit poke);
    exp_t x;
    int n, pc;
    dac_lat = dl; cim_lat = cl; adc_lat = al; hang_ch = hc;
    pc = $countones(wl);
    for (int i = 0; i < NO; i++) begin
      case (mode)
        0: begin code[i] = 8'(50 + (3 * pc) / 2); code[i+NO] = 8'd50; end
        1: begin code[i] = 8'($urandom); code[i+NO] = 8'($urandom); end
        default: begin code[i] = 8'd0; code[i+NO] = 8'd255; end
      endcase
      x.diff[i*9 +: 9] = 9'(int'(code[i]) - int'(code[i+NO]));
    end
    x.tmo = dl >= HANG || cl >= HANG || hc >= 0;
    x.cim_to = cl >= HANG && dl < HANG;
    if (x.tmo) x.diff = last_diff;
    x.n_adc = (dl >= HANG || cl >= HANG) ? 0 : hc >= 0 ? hc + 1 : NC;
    x.dac_n = dl >= HANG ? 255 : dl + 1;
    if (!abort7) begin sb.push_back(x); last_diff = x.diff; end
    @(negedge clk);
    start = 1'b1; wl_in = wl;
    @(negedge clk);
    start = 1'b0; wl_in = {$urandom, $urandom};
    chk("busy_after_start", {busy, dac_valid}, 2'b11);
    chk("wl_spike_latch", wl_spike, wl);
    if (poke) begin
      @(negedge clk); start = 1'b1; wl_in = ~wl;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("wl_spike_hold", wl_spike, wl);
    end
    n = 0;
    if (abort7) begin
      while (!(adc_start && bl_sel == 5'd7) && n < 500) begin @(negedge clk); n++; end
      chk("reach_ch7", n < 500, 1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_reset_outputs", {busy, done, err_timeout, diff_valid, dac_valid, cim_start,
          adc_start, bl_sel, wl_spike, diff_data}, 0);
      last_diff = '0;
      repeat (8) @(negedge clk);
    end else begin
      while (busy && n < 3000) begin @(negedge clk); n++; end
      chk("step_terminates", n < 3000, 1);
    end
  endtask
  initial begin
    logic [63:0] w;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err_timeout, diff_valid, dac_valid, cim_start,
        adc_start, bl_sel, wl_spike, diff_data}, 0);
    rst = 1'b0;
    w = '0;
    while ($countones(w) < 10) w[$urandom_range(0, 63)] = 1'b1;
    run_step(0, w, 0, 1, 1, -1, 0, 0);
    run_step(0, 64'h0, 0, 2, 1, -1, 0, 0);
    run_step(0, '1, 1, 1, 2, -1, 0, 0);
    run_step(2, {$urandom, $urandom}, 0, 1, 1, -1, 0, 0);
    run_step(1, {$urandom, $urandom}, 5, 3, 2, -1, 0, 0);
    run_step(1, {$urandom, $urandom}, 0, HANG, 1, -1, 0, 0);
    run_step(1, {$urandom, $urandom}, 0, 1, 1, -1, 0, 0);
    run_step(1, {$urandom, $urandom}, HANG, 1, 1, -1, 0, 0);
    run_step(1, {$urandom, $urandom}, 0, 1, 1, 3, 0, 0);
    run_step(1, {$urandom, $urandom}, 1, 1, 4, -1, 1, 0);
    @(posedge clk); stray = 1'b1;
    @(posedge clk); stray = 1'b0;
    @(negedge clk);
    chk("stray_ignored", {busy, cim_start, adc_start, done}, 0);
    run_step(1, {$urandom, $urandom}, 0, 1, 1, -1, 0, 1);
    for (int k = 0; k < 8; k++)
      run_step($urandom_range(0, 2), {$urandom, $urandom}, $urandom_range(0, 3),
               $urandom_range(1, 4), $urandom_range(1, 4), -1, 0, 1'($urandom_range(0, 1)));
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
